// File: rtl/cfg_pkg.sv
// -----------------------------------------------------------------------------
// cfg_pkg
// Shared definitions for the audio-codec register-configuration sequencer:
//   - state_t      : sequencer FSM states
//   - CODEC_ADDR   : default 8-bit I2C address byte (7-bit address, R/W = 0)
//   - cfg_rom(idx) : constant codec register table, 16 entries of 16 bits
//                    ({reg_addr[6:0], data[8:0]}); unused slots read as zero
// -----------------------------------------------------------------------------
package cfg_pkg;

  localparam logic [7:0] CODEC_ADDR = 8'h34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XFER,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } state_t;

  // Entry 0 resets the codec, entry 10 activates it; everything in between
  // programs volumes, routing, format and sample rate.
  function automatic logic [15:0] cfg_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    cfg_rom = 16'h1E00;
      4'd1:    cfg_rom = 16'h0017;
      4'd2:    cfg_rom = 16'h0217;
      4'd3:    cfg_rom = 16'h0479;
      4'd4:    cfg_rom = 16'h0679;
      4'd5:    cfg_rom = 16'h0812;
      4'd6:    cfg_rom = 16'h0A00;
      4'd7:    cfg_rom = 16'h0C00;
      4'd8:    cfg_rom = 16'h0E02;
      4'd9:    cfg_rom = 16'h1000;
      4'd10:   cfg_rom = 16'h1201;
      default: cfg_rom = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/cfg_rom_lut.sv
// -----------------------------------------------------------------------------
// cfg_rom_lut
// Combinational lookup of the codec register table. Kept apart from the
// sequencer so the table contents can be changed without touching the FSM.
// Ports:
//   idx_i  [3:0]  table index
//   word_o [15:0] register word at that index
// -----------------------------------------------------------------------------
module cfg_rom_lut
  import cfg_pkg::*;
(
  input  logic [3:0]  idx_i,
  output logic [15:0] word_o
);

  assign word_o = cfg_rom(idx_i);

endmodule

// File: rtl/i2c_cfg_seq.sv
// -----------------------------------------------------------------------------
// i2c_cfg_seq
// Walks the codec register table and hands each entry to the 3-byte I2C write
// engine as {DEV_ADDR, reg[15:0]}. Retries an entry on NACK or timeout, then
// reports completion (cfg_done) or a failing entry (cfg_err, cfg_index).
// Runs entirely on clock_i2c (10 kHz).
// Ports:
//   clock_i2c      in   I2C bit clock, posedge
//   rst            in   asynchronous active-high reset
//   cfg_go         in   level; starts / restarts the sequence from entry 0
//   tr_end         in   engine transfer complete
//   ack            in   engine ack summary, 0 = all bytes ACKed (valid with tr_end)
//   start          out  engine run request, high for the whole transfer
//   i2c_data[23:0] out  frame for the engine, stable while start is high
//   cfg_index[3:0] out  entry currently being sent (failing entry after error)
//   cfg_done       out  sticky, all entries ACKed
//   cfg_err        out  sticky, an entry ran out of retries
// -----------------------------------------------------------------------------
module i2c_cfg_seq
  import cfg_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR   = CODEC_ADDR,
  parameter int unsigned NUM_REGS   = 11,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 40,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clock_i2c,
  input  logic        rst,
  input  logic        cfg_go,
  input  logic        tr_end,
  input  logic        ack,
  output logic        start,
  output logic [23:0] i2c_data,
  output logic [3:0]  cfg_index,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned GW = $clog2(GAP_CYCLES);

  localparam logic [3:0]    LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  state_t        state_q;
  logic          start_q;
  logic [23:0]   i2c_data_q;
  logic [3:0]    idx_q;
  logic          done_q;
  logic          err_q;
  logic [2:0]    retry_q;
  logic [GW-1:0] gap_q;
  logic [TW-1:0] tmo_q;
  logic          nack_q;
  logic          first_q;   // high only on the first cycle after reset

  logic [15:0]   table_word;
  logic [23:0]   i2c_data_d;

  cfg_rom_lut u_rom (
    .idx_i  (idx_q),
    .word_o (table_word)
  );

  assign i2c_data_d = {DEV_ADDR, table_word};

  // NOTE: every register here is state updated on the clock edge, so all
  // assignments are non-blocking; the reset branch is asynchronous and
  // forces start low at once so an in-flight engine transfer aborts.
  always_ff @(posedge clock_i2c or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      i2c_data_q <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      retry_q    <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      nack_q     <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if ((AUTO_START && first_q) || cfg_go) state_q <= ST_LOAD;
        end

        // Hold off until the engine has released tr_end from the previous
        // transfer, so start never rises while tr_end is still high.
        ST_LOAD: begin
          if (!tr_end) begin
            i2c_data_q <= i2c_data_d;
            tmo_q      <= '0;
            start_q    <= 1'b1;
            state_q    <= ST_XFER;
          end
        end

        // A missing tr_end is treated exactly like a NACK.
        ST_XFER: begin
          if (tr_end) begin
            nack_q  <= ack;
            start_q <= 1'b0;
            state_q <= ST_CHECK;
          end else if (tmo_q == TMO_LAST) begin
            nack_q  <= 1'b1;
            start_q <= 1'b0;
            state_q <= ST_CHECK;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        ST_CHECK: begin
          start_q <= 1'b0;
          gap_q   <= '0;
          if (!nack_q) begin
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              retry_q <= '0;
              state_q <= ST_GAP;
            end
          end else if (retry_q < RETRY_MAX) begin
            retry_q <= retry_q + 1'b1;
            state_q <= ST_GAP;
          end else begin
            err_q   <= 1'b1;
            state_q <= ST_FAIL;
          end
        end

        // Idle time lets the engine's cycle counter return to zero and
        // tr_end drop before the next frame is loaded.
        ST_GAP: begin
          if (gap_q == GAP_LAST) state_q <= ST_LOAD;
          else                   gap_q   <= gap_q + 1'b1;
        end

        ST_DONE, ST_FAIL: begin
          start_q <= 1'b0;
          if (cfg_go) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            retry_q <= '0;
            state_q <= ST_LOAD;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign start     = start_q;
  assign i2c_data  = i2c_data_q;
  assign cfg_index = idx_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_i2c_cfg_seq.sv
// -----------------------------------------------------------------------------
// tb_i2c_cfg_seq
// Directed bench for i2c_cfg_seq with a behavioural model of the 3-byte I2C
// write engine: tr_end rises 33 cycles after start, falls 2 cycles after start
// falls. Per-scenario knobs make the model NACK or stay silent on one entry.
// -----------------------------------------------------------------------------
module tb_i2c_cfg_seq;

  logic        clock_i2c = 1'b0;
  logic        rst       = 1'b1;
  logic        cfg_go    = 1'b0;
  logic        tr_end    = 1'b0;
  logic        ack       = 1'b0;
  logic        start;
  logic [23:0] i2c_data;
  logic [3:0]  cfg_index;
  logic        cfg_done;
  logic        cfg_err;

  i2c_cfg_seq dut (
    .clock_i2c (clock_i2c),
    .rst       (rst),
    .cfg_go    (cfg_go),
    .tr_end    (tr_end),
    .ack       (ack),
    .start     (start),
    .i2c_data  (i2c_data),
    .cfg_index (cfg_index),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  always #5 clock_i2c = ~clock_i2c;

  // Expected frames, written out by hand from the codec table.
  logic [23:0] exp_word [0:10] = '{
    24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
    24'h340A00, 24'h340C00, 24'h340E02, 24'h341000, 24'h341201
  };

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- engine model and transfer monitor ----------------------
  int nack_once_idx   = -1;
  int nack_always_idx = -1;
  int mute_idx        = -1;

  bit          once_used  = 1'b0;
  int          hi_cnt     = 0;
  int          lo_cnt     = 0;
  int          gap_len    = 0;
  int          min_gap    = 1000;
  bit          seen_xfer  = 1'b0;
  logic        start_prev = 1'b0;
  logic [23:0] xfer_log [$];
  int          hi_len   [$];

  always @(negedge clock_i2c) begin
    if (rst) begin
      tr_end     = 1'b0;
      ack        = 1'b0;
      once_used  = 1'b0;
      hi_cnt     = 0;
      lo_cnt     = 0;
      gap_len    = 0;
      min_gap    = 1000;
      seen_xfer  = 1'b0;
      start_prev = 1'b0;
      xfer_log.delete();
      hi_len.delete();
    end else begin
      if (start) begin
        if (!start_prev) begin
          xfer_log.push_back(i2c_data);
          if (seen_xfer && gap_len < min_gap) min_gap = gap_len;
          seen_xfer = 1'b1;
          gap_len   = 0;
          hi_cnt    = 0;
        end
        hi_cnt++;
        lo_cnt = 0;
        if (hi_cnt >= 33 && !tr_end && int'(cfg_index) != mute_idx) begin
          tr_end = 1'b1;
          ack    = 1'b0;
          if (int'(cfg_index) == nack_always_idx) ack = 1'b1;
          if (int'(cfg_index) == nack_once_idx && !once_used) begin
            ack       = 1'b1;
            once_used = 1'b1;
          end
        end
      end else begin
        if (start_prev) hi_len.push_back(hi_cnt);
        gap_len++;
        if (tr_end) begin
          lo_cnt++;
          if (lo_cnt >= 2) begin
            tr_end = 1'b0;
            ack    = 1'b0;
            lo_cnt = 0;
          end
        end
      end
      start_prev = start;
    end
  end

  // ---------------- helpers -------------------------------------------------
  task automatic do_reset();
    @(negedge clock_i2c);
    rst    = 1'b1;
    cfg_go = 1'b0;
    repeat (3) @(negedge clock_i2c);
    rst = 1'b0;
  endtask

  function automatic logic [23:0] log_at(input int i);
    if (i < xfer_log.size()) return xfer_log[i];
    return 24'hxxxxxx;
  endfunction

  function automatic int count_word(input logic [23:0] w);
    int n = 0;
    foreach (xfer_log[i]) if (xfer_log[i] == w) n++;
    return n;
  endfunction

  // ---------------- stimulus ------------------------------------------------
  initial begin
    int base;

    // Reset values while rst is held.
    repeat (2) @(negedge clock_i2c);
    check("rst_start",    32'(start),     32'd0);
    check("rst_data",     32'(i2c_data),  32'd0);
    check("rst_index",    32'(cfg_index), 32'd0);
    check("rst_done",     32'(cfg_done),  32'd0);
    check("rst_err",      32'(cfg_err),   32'd0);
    rst = 1'b0;

    // 1: auto-start, clean pass through all 11 entries.
    for (int c = 0; c < 2000 && !cfg_done; c++) @(negedge clock_i2c);
    check("s1_done",  32'(cfg_done),  32'd1);
    check("s1_err",   32'(cfg_err),   32'd0);
    check("s1_index", 32'(cfg_index), 32'd10);
    check("s1_count", 32'(xfer_log.size()), 32'd11);
    for (int i = 0; i < 11; i++) check($sformatf("s1_word%0d", i), 32'(log_at(i)), 32'(exp_word[i]));
    check("s1_gap_ge4", 32'(min_gap >= 4), 32'd1);
    repeat (20) @(negedge clock_i2c);
    check("s1_idle_start", 32'(start), 32'd0);
    check("s1_no_extra",   32'(xfer_log.size()), 32'd11);

    // 5: one-cycle cfg_go pulse from DONE re-sends the whole table.
    base   = xfer_log.size();
    cfg_go = 1'b1;
    @(negedge clock_i2c);
    cfg_go = 1'b0;
    check("rs_done_clr", 32'(cfg_done),  32'd0);
    check("rs_index0",   32'(cfg_index), 32'd0);
    for (int c = 0; c < 2000 && !cfg_done; c++) @(negedge clock_i2c);
    check("rs_done",  32'(cfg_done), 32'd1);
    check("rs_count", 32'(xfer_log.size() - base), 32'd11);
    check("rs_first", 32'(log_at(base)),      32'h341E00);
    check("rs_last",  32'(log_at(base + 10)), 32'h341201);

    // 2: a single NACK on entry 3 causes exactly one repeat.
    nack_once_idx = 3;
    do_reset();
    for (int c = 0; c < 2000 && !cfg_done; c++) @(negedge clock_i2c);
    check("s2_done",   32'(cfg_done), 32'd1);
    check("s2_err",    32'(cfg_err),  32'd0);
    check("s2_count",  32'(xfer_log.size()), 32'd12);
    check("s2_try1",   32'(log_at(3)),  32'h340479);
    check("s2_try2",   32'(log_at(4)),  32'h340479);
    check("s2_next",   32'(log_at(5)),  32'h340679);
    check("s2_last",   32'(log_at(11)), 32'h341201);
    nack_once_idx = -1;

    // 3: entry 5 NACKs forever -> 4 attempts, then FAIL.
    nack_always_idx = 5;
    do_reset();
    for (int c = 0; c < 2000 && !cfg_err; c++) @(negedge clock_i2c);
    check("s3_err",      32'(cfg_err),   32'd1);
    check("s3_done",     32'(cfg_done),  32'd0);
    check("s3_index",    32'(cfg_index), 32'd5);
    check("s3_attempts", 32'(count_word(24'h340812)), 32'd4);
    check("s3_count",    32'(xfer_log.size()), 32'd9);
    repeat (60) @(negedge clock_i2c);
    check("s3_start_low", 32'(start), 32'd0);
    check("s3_no_more",   32'(xfer_log.size()), 32'd9);
    nack_always_idx = -1;

    // 4: engine never answers on entry 0 -> 40-cycle timeouts, 4 attempts.
    mute_idx = 0;
    do_reset();
    for (int c = 0; c < 2000 && !cfg_err; c++) @(negedge clock_i2c);
    check("s4_err",      32'(cfg_err),   32'd1);
    check("s4_index",    32'(cfg_index), 32'd0);
    check("s4_attempts", 32'(count_word(24'h341E00)), 32'd4);
    check("s4_count",    32'(xfer_log.size()), 32'd4);
    check("s4_len_first", 32'(hi_len.size() > 0 ? hi_len[0] : -1), 32'd40);
    check("s4_len_last",  32'(hi_len.size() > 3 ? hi_len[3] : -1), 32'd40);
    mute_idx = -1;

    // 6: reset at cycle 15 of entry 6's transfer.
    do_reset();
    for (int c = 0; c < 2000 && !(start && cfg_index == 4'd6); c++) @(negedge clock_i2c);
    check("s6_reach_e6", 32'(cfg_index), 32'd6);
    repeat (14) @(negedge clock_i2c);
    check("s6_mid_start", 32'(start), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("s6_rst_start", 32'(start),     32'd0);
    check("s6_rst_data",  32'(i2c_data),  32'd0);
    check("s6_rst_index", 32'(cfg_index), 32'd0);
    check("s6_rst_done",  32'(cfg_done),  32'd0);
    check("s6_rst_err",   32'(cfg_err),   32'd0);
    repeat (2) @(negedge clock_i2c);
    rst = 1'b0;
    for (int c = 0; c < 100 && xfer_log.size() == 0; c++) @(negedge clock_i2c);
    check("s6_restart", 32'(log_at(0)), 32'h341E00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_seq.md
Name: i2c_cfg_seq

Overview:
Register-configuration sequencer for the audio codec control bus. Walks a fixed table of 16-bit codec register writes and frames each as a 24-bit word {DEV_ADDR, reg[15:0]}. Drives the downstream 3-byte I2C write engine via start/i2c_data, monitors tr_end/ack, retries on NACK, and reports done/error to the SoC. Runs on the 10 kHz clock_i2c domain.

Parameters:
DEV_ADDR, 8'h34, 7-bit device address plus R/W=0, placed in i2c_data[23:16]
NUM_REGS, 11, number of table entries sent, 1..16
MAX_RETRY, 3, retries per entry after the first NACK/timeout, 0..7
GAP_CYCLES, 4, idle cycles with start=0 between transfers, minimum 3
TIMEOUT, 40, cycles in XFER without tr_end before a timeout, must exceed 34
AUTO_START, 1, 1 = begin the sequence on the first cycle after reset

Ports:
clock_i2c  in  1  10 kHz I2C bit clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
cfg_go  in  1  level; in IDLE, or in DONE/FAIL, a 1 (re)starts the sequence from index 0
tr_end  in  1  engine transfer complete; high from ~33 cycles after start rises until 2 cycles after start falls
ack  in  1  engine acknowledge summary; 0 = all three bytes ACKed; valid while tr_end=1
start  out  1  engine run request; held high for the whole transfer
i2c_data  out  24  {DEV_ADDR, table[cfg_index]}; stable whenever start=1
cfg_index  out  4  table entry currently being sent
cfg_done  out  1  sticky; all NUM_REGS entries ACKed
cfg_err  out  1  sticky; an entry exhausted its retries

Behaviour:
- Reset values: start=0, i2c_data=0, cfg_index=0, cfg_done=0, cfg_err=0, retry count=0, state=IDLE, gap and timeout counters=0.
- Reset mid-transfer: start drops immediately, so the engine aborts. No recovery STOP is generated.
- States:
  - IDLE: if AUTO_START on the first post-reset cycle, or if cfg_go=1 -> LOAD.
  - LOAD: i2c_data <= {DEV_ADDR, table[cfg_index]}; timeout counter cleared -> XFER.
  - XFER: start=1 and the timeout counter increments. On tr_end=1, capture ack -> CHECK. If the counter reaches TIMEOUT, treat as NACK -> CHECK.
  - CHECK: start <= 0.
    - ack=0 and cfg_index=NUM_REGS-1 -> DONE.
    - ack=0 otherwise: cfg_index++, retry count cleared -> GAP.
    - NACK and retry count < MAX_RETRY: retry count++, cfg_index unchanged -> GAP.
    - NACK and retries exhausted -> FAIL.
  - GAP: start=0 for GAP_CYCLES cycles. This guarantees the engine counter returns to 0 and tr_end clears. Then -> LOAD.
  - DONE: cfg_done=1, start=0. cfg_go=1 -> clear flags, cfg_index=0 -> LOAD.
  - FAIL: cfg_err=1, cfg_index holds the failing entry, start=0. cfg_go=1 restarts as in DONE.
- start never rises while tr_end=1. If LOAD is entered with tr_end still high, stay in LOAD until tr_end=0.
- i2c_data changes only in LOAD, never while start=1.
- Nominal per-entry time is ~33 (XFER) + 1 (CHECK) + GAP_CYCLES + 1 (LOAD) cycles. The full 11-entry pass takes about 430 cycles, about 43 ms.
- cfg_go held high in DONE/FAIL causes a continuous re-run. This is intended for soak testing.

Default table (reg[15:9]=register address, reg[8:0]=data):
0:16'h1E00 (reset)  1:16'h0017  2:16'h0217  3:16'h0479  4:16'h0679  5:16'h0812
6:16'h0A00  7:16'h0C00  8:16'h0E02  9:16'h1000  10:16'h1201 (active)
Entries at index >= NUM_REGS are 16'h0000 and are never sent.

Decomposition:
- Shared package cfg_pkg:
  - state enum
  - codec register table as a constant function cfg_rom(idx) -> 16 bits
  - CODEC_ADDR constant
- Sub-module cfg_rom_lut: combinational table lookup. It is separate so the table can change without touching the FSM.
- The FSM, counters and output registers stay in i2c_cfg_seq.

Test Plan:
- Reset/auto-start: the bench model of the engine raises tr_end 33 cycles after start and returns ack=0.
  - Required: 11 transfers with i2c_data=24'h341E00, 24'h340017 ... 24'h341201 in order.
  - cfg_done=1, cfg_err=0, cfg_index=10.
  - start low for >=4 cycles between transfers.
- Single NACK: model returns ack=1 once on entry 3.
  - Required: entry 3 (24'h340479) is sent twice.
  - Sequence completes with cfg_done=1, and a total of 12 transfers are observed.
- Persistent NACK: ack=1 always on entry 5.
  - Required: exactly 4 attempts of 24'h340812, then cfg_err=1, cfg_index=5, cfg_done=0, start=0 thereafter.
- Timeout: model never raises tr_end on entry 0.
  - Required: start falls after 40 cycles in XFER and retries 3 times.
  - Ends with cfg_err=1, cfg_index=0.
- Restart: after DONE, pulse cfg_go=1 for one cycle.
  - Required: cfg_done clears, cfg_index=0, and the full sequence is re-sent.
- Reset mid-operation: assert rst during entry 6 at cycle 15 of XFER.
  - Required: start=0 and outputs at reset values in the same cycle.
  - After release with AUTO_START=1, the sequence restarts at 24'h341E00.
